// File: rtl/divmod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divmod_pkg
// Description : Shared definitions for the iterative divider. This package
//               holds the state encoding, the counter-width helper and the
//               divide-by-zero flag values.
// Revision    : 1.0 - initial release
// ============================================================================
package divmod_pkg;

   // FIX is reachable only when DIVMOD_SIGNED_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   localparam logic c_dz_none = 1'b0;
   localparam logic c_dz_zero = 1'b1;

   // Returns the number of bits needed to hold the iteration count WIDTH/STEP.
   function automatic int cnt_width(input int width, input int step);
      return $clog2(width / step + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/divmod_if.sv
`default_nettype none
// ============================================================================
// Module      : divmod_if
// Description : Start/busy/valid handshake and operand/result bundle for the
//               iterative divider. The master modport belongs to the requester
//               and the slave modport belongs to the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface divmod_if #(
   parameter int WIDTH = 8
);
   import divmod_pkg::*;

   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             dz;

   modport master (
      output start, signed_op, a, b,
      input  busy, valid, q, r, dz
   );

   modport slave (
      input  start, signed_op, a, b,
      output busy, valid, q, r, dz
   );

endinterface
`default_nettype wire

// File: rtl/divmod_step.sv
`default_nettype none
// ============================================================================
// Module      : divmod_step
// Description : One combinational restoring-division step. This step shifts
//               {rem,quo} left by one bit. It subtracts the divisor when the
//               shifted remainder is large enough and records the quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module divmod_step
   import divmod_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   // The shifted remainder needs one extra bit, so the compare never wraps.
   // The incoming remainder is always below the divisor, so the result fits
   // in WIDTH bits again and the top bit can be dropped.
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_rem_nx;
   logic           w_fits;
   logic           w_unused_msb;

   assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
   assign w_fits   = (w_rem_sh >= {1'b0, i_div});
   assign w_rem_nx = w_fits ? (w_rem_sh - {1'b0, i_div}) : w_rem_sh;

   assign {w_unused_msb, o_rem} = w_rem_nx;
   assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/divmod_iter.sv
`default_nettype none
// ============================================================================
// Module      : divmod_iter
// Description : Iterative restoring divider. It resolves STEP quotient bits
//               per clock and returns the quotient, the remainder and a
//               divide-by-zero flag through a start/busy/valid handshake.
//               Build option: define DIVMOD_SIGNED_EN to honour signed_op.
//               This adds a FIX state that applies the two's-complement
//               result signs.
// Revision    : 1.0 - initial release
// ============================================================================
module divmod_iter
   import divmod_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic      clock,
   input  logic      reset,
   divmod_if.slave   bus
);

   localparam int                 c_cnt_w   = cnt_width(WIDTH, STEP);
   localparam logic [c_cnt_w-1:0] c_runs    = c_cnt_w'(WIDTH / STEP);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

   if ((STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_step
      $error("divmod_iter: STEP must be a positive divisor of WIDTH");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_done_run;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [c_cnt_w-1:0] r_cnt;
   logic             r_dz_pend;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_dz;
   logic             r_valid;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

`ifdef DIVMOD_SIGNED_EN
   logic w_a_neg;
   logic w_b_neg;
   logic r_fix;
   logic r_neg_q;
   logic r_neg_r;

   assign w_a_neg = bus.signed_op & bus.a[WIDTH-1];
   assign w_b_neg = bus.signed_op & bus.b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
   assign w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;
`else
   logic w_unused_signed;

   assign w_unused_signed = bus.signed_op;
   assign w_a_mag = bus.a;
   assign w_b_mag = bus.b;
`endif

   // Restoring-step chain: STEP steps unrolled per clock.
   logic [WIDTH-1:0] w_rem_ch [STEP+1];
   logic [WIDTH-1:0] w_quo_ch [STEP+1];

   assign w_rem_ch[0] = r_rem;
   assign w_quo_ch[0] = r_quo;

   for (genvar gi = 0; gi < STEP; gi++) begin : g_step
      divmod_step #(
         .WIDTH (WIDTH)
      ) u_step (
         .i_rem (w_rem_ch[gi]),
         .i_quo (w_quo_ch[gi]),
         .i_div (r_div),
         .o_rem (w_rem_ch[gi+1]),
         .o_quo (w_quo_ch[gi+1])
      );
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: accept in IDLE, count down in RUN, optionally sign-fix.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done_run  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == c_cnt_one) begin
`ifdef DIVMOD_SIGNED_EN
               if (r_fix) begin
                  w_state_nxt = ST_FIX;
               end else begin
                  w_done_run  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
`else
               w_done_run  = 1'b1;
               w_state_nxt = ST_IDLE;
`endif
            end
         end
`ifdef DIVMOD_SIGNED_EN
         ST_FIX:  w_state_nxt = ST_IDLE;
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, iteration update and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_cnt     <= '0;
         r_dz_pend <= c_dz_none;
         r_q       <= '0;
         r_r       <= '0;
         r_dz      <= c_dz_none;
         r_valid   <= 1'b0;
`ifdef DIVMOD_SIGNED_EN
         r_fix     <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_div     <= w_b_mag;
            r_cnt     <= c_runs;
            r_dz_pend <= (bus.b == '0) ? c_dz_zero : c_dz_none;
`ifdef DIVMOD_SIGNED_EN
            r_fix     <= bus.signed_op;
            // A zero divisor keeps q = all ones, which already reads as -1.
            r_neg_q   <= (w_a_neg ^ w_b_neg) && (bus.b != '0);
            r_neg_r   <= w_a_neg;
`endif
         end
         if (r_state == ST_RUN) begin
            r_rem <= w_rem_ch[STEP];
            r_quo <= w_quo_ch[STEP];
            r_cnt <= r_cnt - c_cnt_one;
         end
         if (w_done_run) begin
            r_q     <= w_quo_ch[STEP];
            r_r     <= w_rem_ch[STEP];
            r_dz    <= r_dz_pend;
            r_valid <= 1'b1;
         end
`ifdef DIVMOD_SIGNED_EN
         if (r_state == ST_FIX) begin
            r_q     <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
            r_r     <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
            r_dz    <= r_dz_pend;
            r_valid <= 1'b1;
         end
`endif
      end
   end

   assign bus.busy  = (r_state != ST_IDLE);
   assign bus.valid = r_valid;
   assign bus.q     = r_q;
   assign bus.r     = r_r;
   assign bus.dz    = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_divmod_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_divmod_iter
// Description : Self-checking bench for divmod_iter. Four instances with
//               WIDTH=8 and STEP = 1, 2, 4 and 8 share one stimulus stream.
//               A per-instance arithmetic model predicts valid, busy and the
//               held results on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divmod_iter;

`ifdef DIVMOD_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic       clock    = 1'b0;
   logic       reset    = 1'b1;
   logic       tb_start = 1'b0;
   logic       tb_sgn   = 1'b0;
   logic [7:0] tb_a     = 8'h00;
   logic [7:0] tb_b     = 8'h00;

   int n_vec  = 0;
   int n_bad  = 0;
   bit chk_en = 1'b0;
   int ecnt   = 0;
   int lat_tab [4] = '{8, 4, 2, 1};

   logic [7:0] q_all [4];
   logic [7:0] r_all [4];
   logic       valid_all [4];
   logic       busy_all [4];
   logic       dz_all [4];

   always #5 clock = ~clock;

   // Counts edges; in the cycle after edge e this holds e.
   always @(posedge clock) ecnt <= ecnt + 1;

   // Reference result from plain integer arithmetic.
   function automatic void ref_div(input logic [7:0] a, input logic [7:0] b, input bit s,
                                   output logic [7:0] q, output logic [7:0] r, output bit dz);
      int sa, sb, qi, ri;
      if (b == 8'h00) begin
         q = 8'hFF; r = a; dz = 1'b1;
      end else if (s) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         qi = sa / sb;
         ri = sa % sb;
         q = qi[7:0]; r = ri[7:0]; dz = 1'b0;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int S = 1 << gi;
      localparam int C = 8 / S;

      divmod_if #(.WIDTH(8)) bus ();

      assign bus.start     = tb_start;
      assign bus.signed_op = tb_sgn;
      assign bus.a         = tb_a;
      assign bus.b         = tb_b;
      assign q_all[gi]     = bus.q;
      assign r_all[gi]     = bus.r;
      assign valid_all[gi] = bus.valid;
      assign busy_all[gi]  = bus.busy;
      assign dz_all[gi]    = bus.dz;

      divmod_iter #(
         .WIDTH (8),
         .STEP  (S)
      ) dut (
         .clock (clock),
         .reset (reset),
         .bus   (bus)
      );

      bit         pend = 1'b0;
      int         left = 0;
      logic [7:0] pq = 8'h00, pr = 8'h00, hq = 8'h00, hr = 8'h00;
      bit         pdz = 1'b0, hdz = 1'b0, ev = 1'b0, eb = 1'b0;

      // Model: one operation in flight, result due C (+1 signed) edges after acceptance.
      always @(posedge clock) begin
         if (reset) begin
            pend = 1'b0; left = 0; hq = 8'h00; hr = 8'h00; hdz = 1'b0;
            ev = 1'b0; eb = 1'b0;
         end else begin
            ev = 1'b0;
            if (pend) begin
               left--;
               if (left == 0) begin
                  pend = 1'b0; hq = pq; hr = pr; hdz = pdz; ev = 1'b1;
               end
            end else if (tb_start) begin
               ref_div(tb_a, tb_b, tb_sgn & SIGNED_BUILD, pq, pr, pdz);
               left = C + int'(tb_sgn & SIGNED_BUILD);
               pend = 1'b1;
            end
            eb = pend;
         end
      end

      // Per-cycle compare against the model.
      always @(negedge clock) begin
         if (chk_en) begin
            n_vec++;
            if (bus.valid !== ev || bus.busy !== eb || bus.q !== hq || bus.r !== hr || bus.dz !== hdz) begin
               n_bad++;
               $display("FAIL cycle step%0d t=%0t: valid=%b busy=%b q=%h r=%h dz=%b, required valid=%b busy=%b q=%h r=%h dz=%b",
                        S, $time, bus.valid, bus.busy, bus.q, bus.r, bus.dz, ev, eb, hq, hr, hdz);
            end
         end
      end
   end

   // Checks held results of all instances against literal values.
   task automatic check_lit(input string name, input logic [7:0] eq, input logic [7:0] er, input bit edz);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (q_all[i] !== eq || r_all[i] !== er || dz_all[i] !== edz) begin
            n_bad++;
            $display("FAIL %s step%0d: q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                     name, 1 << i, q_all[i], r_all[i], dz_all[i], eq, er, edz);
         end
      end
   endtask

   // Issues one operation and waits (bounded) for every instance to deliver it.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b, input bit s,
                         input bit lit, input logic [7:0] eq, input logic [7:0] er, input bit edz);
      bit got [4];
      int k;
      int lat;
      for (int i = 0; i < 4; i++) got[i] = 1'b0;
      @(negedge clock);
      tb_a = a; tb_b = b; tb_sgn = s; tb_start = 1'b1;
      k = ecnt + 1;
      @(negedge clock);
      tb_start = 1'b0;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (valid_all[i] && !got[i]) begin
               got[i] = 1'b1;
               if (lit) begin
                  lat = lat_tab[i] + int'(s & SIGNED_BUILD);
                  n_vec++;
                  if (ecnt - k != lat) begin
                     n_bad++;
                     $display("FAIL %s latency step%0d: valid after edge k+%0d, required k+%0d",
                              name, 1 << i, ecnt - k, lat);
                  end
               end
            end
         end
         if (got[0] && got[1] && got[2] && got[3]) break;
         @(negedge clock);
      end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (!got[i]) begin
            n_bad++;
            $display("FAIL %s timeout step%0d: valid=0 after 40 cycles, required a valid pulse", name, 1 << i);
         end
      end
      if (lit) check_lit(name, eq, er, edz);
   endtask

   initial begin
      logic [7:0] ra, rb;
      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      reset  = 1'b0;
      check_lit("reset", 8'h00, 8'h00, 1'b0);

      run_op("15/2",  8'd15,  8'd2,  1'b0, 1'b1, 8'd7,   8'd1,  1'b0);
      run_op("200/7", 8'd200, 8'd7,  1'b0, 1'b1, 8'd28,  8'd4,  1'b0);
      run_op("255/1", 8'hFF,  8'h01, 1'b0, 1'b1, 8'hFF,  8'h00, 1'b0);
      run_op("3/10",  8'd3,   8'd10, 1'b0, 1'b1, 8'd0,   8'd3,  1'b0);
      run_op("5A/0",  8'h5A,  8'h00, 1'b0, 1'b1, 8'hFF,  8'h5A, 1'b1);

      // Back-to-back: start stays high, so each instance accepts 9/3 in its valid cycle.
      @(negedge clock);
      tb_a = 8'h5A; tb_b = 8'h00; tb_sgn = 1'b0; tb_start = 1'b1;
      @(negedge clock);
      tb_a = 8'd9; tb_b = 8'd3;
      repeat (10) @(negedge clock);
      tb_start = 1'b0;
      repeat (20) @(negedge clock);
      check_lit("b2b 9/3", 8'd3, 8'd0, 1'b0);

      // A start issued while busy is dropped.
      @(negedge clock);
      tb_a = 8'd100; tb_b = 8'd7; tb_start = 1'b1;
      @(negedge clock);
      tb_a = 8'd1; tb_b = 8'd1;
      @(negedge clock);
      tb_start = 1'b0;
      repeat (12) @(negedge clock);
      check_lit("busy ignore 100/7", 8'd14, 8'd2, 1'b0);

`ifdef DIVMOD_SIGNED_EN
      run_op("-7/2 s",    8'hF9, 8'h02, 1'b1, 1'b1, 8'hFD, 8'hFF, 1'b0);
      run_op("MIN/-1 s",  8'h80, 8'hFF, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0);
      run_op("-7/0 s",    8'hF9, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hF9, 1'b1);
`else
      run_op("F9/2 sgn ignored", 8'hF9, 8'h02, 1'b1, 1'b1, 8'h7C, 8'h01, 1'b0);
`endif

      // Reset mid-run abandons the operation.
      @(negedge clock);
      tb_a = 8'd200; tb_b = 8'd7; tb_sgn = 1'b0; tb_start = 1'b1;
      @(negedge clock);
      tb_start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_vec++;
      if (busy_all[0] !== 1'b0 || valid_all[0] !== 1'b0 || q_all[0] !== 8'h00 || r_all[0] !== 8'h00) begin
         n_bad++;
         $display("FAIL reset mid-run: busy=%b valid=%b q=%h r=%h, required busy=0 valid=0 q=00 r=00",
                  busy_all[0], valid_all[0], q_all[0], r_all[0]);
      end
      repeat (15) @(negedge clock);

      // Random sweep, with the model checking every cycle.
      for (int n = 0; n < 300; n++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         run_op("random", ra, rb, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00, 1'b0);
      end

      repeat (4) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
